// File: rtl/scie_pkg.sv
// ============================================================================
// Module : scie_pkg
// Brief  : Shared types, opcodes and sizes for the SCIE complex FIR.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package scie_pkg;

    localparam int NUM_TAPS = 5;
    localparam int DATA_W   = 16;
    localparam int PROD_W   = 2 * DATA_W;
    localparam int ACC_W    = PROD_W + 3;

    localparam logic [6:0] OP_COEF = 7'h0B;
    localparam logic [6:0] OP_PUSH = 7'h2B;
    localparam logic [6:0] OP_READ = 7'h5B;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } complex_t;

    typedef struct packed {
        logic signed [PROD_W-1:0] re;
        logic signed [PROD_W-1:0] im;
    } cprod_t;

    typedef struct packed {
        logic signed [ACC_W-1:0] re;
        logic signed [ACC_W-1:0] im;
    } cacc_t;

endpackage

`default_nettype wire

// File: rtl/complex_mul.sv
// ============================================================================
// Module : complex_mul
// Brief  : Combinational 16x16 complex multiply with a 32-bit real/imag result.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module complex_mul
    import scie_pkg::*;
(
    input  complex_t i_a,
    input  complex_t i_b,
    output cprod_t   o_p
);

    logic signed [PROD_W-1:0] w_rr;
    logic signed [PROD_W-1:0] w_ii;
    logic signed [PROD_W-1:0] w_ri;
    logic signed [PROD_W-1:0] w_ir;

    always_comb begin
        w_rr   = PROD_W'($signed(i_a.re)) * PROD_W'($signed(i_b.re));
        w_ii   = PROD_W'($signed(i_a.im)) * PROD_W'($signed(i_b.im));
        w_ri   = PROD_W'($signed(i_a.re)) * PROD_W'($signed(i_b.im));
        w_ir   = PROD_W'($signed(i_a.im)) * PROD_W'($signed(i_b.re));
        o_p.re = w_rr - w_ii;
        o_p.im = w_ri + w_ir;
    end

endmodule

`default_nettype wire

// File: rtl/scie_pipelined.sv
// ============================================================================
// Module : scie_pipelined
// Brief  : Five-tap complex FIR driven by custom instructions, two-stage MAC.
//          Build option SCIE_SATURATE_EN: saturate results instead of wrapping.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module scie_pipelined
    import scie_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     io_valid,
    input  logic [31:0]              io_insn,
    input  logic signed [DATA_W-1:0] io_rs1_real,
    input  logic signed [DATA_W-1:0] io_rs1_imag,
    input  logic [31:0]              io_rs2,
    output logic signed [DATA_W-1:0] io_rd_real,
    output logic signed [DATA_W-1:0] io_rd_imag
);

    complex_t coef_q [NUM_TAPS];
    complex_t coef_d [NUM_TAPS];
    complex_t x_q    [NUM_TAPS];
    complex_t x_d    [NUM_TAPS];
    cprod_t   prod_q [NUM_TAPS];
    cprod_t   prod_d [NUM_TAPS];
    cprod_t   w_prod [NUM_TAPS];
    cacc_t    sum_q;
    cacc_t    sum_d;
    complex_t rd_q;
    complex_t rd_d;

    // The sum register's state is observed only through reads, which capture
    // the value it loads on the same edge.
    logic unused_bits;
    assign unused_bits = ^{io_insn[31:7], io_rs2[31:3], sum_q};

`ifdef SCIE_SATURATE_EN
    function automatic logic signed [DATA_W-1:0] narrow(input logic signed [ACC_W-1:0] v);
        if (v > ACC_W'(32767))
            narrow = 16'sh7FFF;
        else if (v < -ACC_W'(32768))
            narrow = 16'sh8000;
        else
            narrow = v[DATA_W-1:0];
    endfunction
`else
    function automatic logic signed [DATA_W-1:0] narrow(input logic signed [ACC_W-1:0] v);
        narrow = v[DATA_W-1:0];
    endfunction
`endif

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
        complex_mul u_mul (
            .i_a (coef_q[k]),
            .i_b (x_q[k]),
            .o_p (w_prod[k])
        );
    end

    always_comb begin
        coef_d = coef_q;
        x_d    = x_q;
        rd_d   = rd_q;
        prod_d = w_prod;
        sum_d  = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            sum_d.re = sum_d.re + ACC_W'($signed(prod_q[k].re));
            sum_d.im = sum_d.im + ACC_W'($signed(prod_q[k].im));
        end

        if (io_valid) begin
            case (io_insn[6:0])
                OP_COEF: begin
                    if (io_rs2[2:0] < 3'(NUM_TAPS))
                        coef_d[io_rs2[2:0]] = '{re: io_rs1_real, im: io_rs1_imag};
                end
                OP_PUSH: begin
                    for (int k = NUM_TAPS - 1; k > 0; k--)
                        x_d[k] = x_q[k-1];
                    x_d[0] = '{re: io_rs1_real, im: io_rs1_imag};
                end
                // Reads take the sum being loaded this edge so a push is
                // visible to a read two edges later.
                OP_READ: begin
                    rd_d.re = narrow(sum_d.re);
                    rd_d.im = narrow(sum_d.im);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                coef_q[k] <= '0;
                x_q[k]    <= '0;
                prod_q[k] <= '0;
            end
            sum_q <= '0;
            rd_q  <= '0;
        end else begin
            coef_q <= coef_d;
            x_q    <= x_d;
            prod_q <= prod_d;
            sum_q  <= sum_d;
            rd_q   <= rd_d;
        end
    end

    assign io_rd_real = rd_q.re;
    assign io_rd_imag = rd_q.im;

endmodule

`default_nettype wire

// File: tb/tb_scie_pipelined.sv
// ============================================================================
// Module : tb_scie_pipelined
// Brief  : Directed self-checking bench for the SCIE complex FIR.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_scie_pipelined;
    import scie_pkg::*;

    logic               clock = 1'b0;
    logic               reset;
    logic               io_valid;
    logic [31:0]        io_insn;
    logic signed [15:0] io_rs1_real;
    logic signed [15:0] io_rs1_imag;
    logic [31:0]        io_rs2;
    logic signed [15:0] io_rd_real;
    logic signed [15:0] io_rd_imag;

    int n_cmp = 0;
    int n_err = 0;

    scie_pipelined dut (
        .clock       (clock),
        .reset       (reset),
        .io_valid    (io_valid),
        .io_insn     (io_insn),
        .io_rs1_real (io_rs1_real),
        .io_rs1_imag (io_rs1_imag),
        .io_rs2      (io_rs2),
        .io_rd_real  (io_rd_real),
        .io_rd_imag  (io_rd_imag)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: observed (%0d,%0d) expected (%0d,%0d)", tag,
                     $signed(obs[31:16]), $signed(obs[15:0]),
                     $signed(exp_v[31:16]), $signed(exp_v[15:0]));
        end
    endtask

    task automatic chk(input string tag, input int re, input int im);
        logic [15:0] er;
        logic [15:0] ei;
        er = 16'(re);
        ei = 16'(im);
        check_val(tag, {io_rd_real, io_rd_imag}, {er, ei});
    endtask

    // Drive one instruction from a falling edge; it executes on the next rising edge.
    task automatic step(input logic v, input logic [6:0] op, input int re, input int im, input int rs2);
        io_valid    = v;
        io_insn     = {25'h1A5F3C1, op};
        io_rs1_real = 16'(re);
        io_rs1_imag = 16'(im);
        io_rs2      = 32'(rs2);
        @(negedge clock);
    endtask

    task automatic coef(input int idx, input int re, input int im);
        step(1'b1, OP_COEF, re, im, idx);
    endtask

    task automatic push(input int re, input int im);
        step(1'b1, OP_PUSH, re, im, 0);
    endtask

    task automatic idle();
        step(1'b0, 7'h00, 0, 0, 0);
    endtask

    task automatic rd();
        step(1'b1, OP_READ, 0, 0, 0);
    endtask

    initial begin
        reset       = 1'b0;
        io_valid    = 1'b0;
        io_insn     = '0;
        io_rs1_real = '0;
        io_rs1_imag = '0;
        io_rs2      = '0;
        repeat (2) @(negedge clock);
        chk("reset_rd", 0, 0);
        reset = 1'b1;
        @(negedge clock);

        coef(0, -15, 19);
        coef(1, -18, -44);
        coef(2, -11, -40);
        coef(3, -39, 2);
        coef(4, 11, -36);

        push(-21, -9);  idle(); rd(); chk("push1", 486, -264);
        push(29, 25);   idle(); rd(); chk("push2", -928, 1262);
        push(-25, -5);  idle(); rd(); chk("push3", 919, -1187);
        push(-14, 13);  idle(); rd(); chk("push4", 1711, -397);
        push(-27, 16);  idle(); rd(); chk("push5", -736, 424);
        push(29, -22);  idle(); rd(); chk("push6_drop", 4051, 1574);

        push(0, 0); rd(); chk("read_e1_old", 4051, 1574);
        rd();             chk("read_e2_new", -488, 334);

        step(1'b0, OP_PUSH, 111, 222, 0);
        step(1'b0, OP_READ, 0, 0, 0);
        chk("invalid_rd_hold", -488, 334);
        step(1'b0, OP_COEF, 500, 500, 1);
        step(1'b1, 7'h33, 300, -300, 2);
        step(1'b1, 7'h0F, 77, 77, 0);
        chk("unknown_op_rd_hold", -488, 334);
        idle(); idle(); rd(); chk("noop_state_kept", -488, 334);

        coef(7, 1000, 1000);
        coef(5, 1000, 1000);
        coef(6, -1000, 1000);
        idle(); idle(); rd(); chk("coef_idx_oob", -488, 334);

        push(7, 7);
        #2 reset = 1'b0;
        #1 chk("async_reset_rd", 0, 0);
        @(negedge clock);
        reset = 1'b1;
        push(5, 5); idle(); rd(); chk("post_reset_zero", 0, 0);

        for (int k = 0; k < NUM_TAPS; k++) coef(k, 32767, 0);
        for (int k = 0; k < NUM_TAPS; k++) push(32767, 0);
        idle(); rd();
`ifdef SCIE_SATURATE_EN
        chk("overflow_sat", 32767, 0);
`else
        chk("overflow_wrap", 5, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
